// File: rtl/sc_bitstream_decoder.sv
// -----------------------------------------------------------------------------
// sc_bitstream_decoder
//   Converts a serial unipolar stochastic bitstream frame of BITSTREAM bits
//   into a signed QUANT-bit value. The decoder counts the ones in each frame
//   and maps the count linearly onto the signed range. The result is held in
//   an output buffer behind a valid/ready handshake.
//
// Ports
//   clk        in   1              clock, rising edge
//   rst_n      in   1              asynchronous active-low reset
//   clear      in   1              synchronous flush: abort frame, drop result
//   bit_in     in   1              stochastic bit
//   bit_valid  in   1              bit_in is valid this cycle
//   bit_ready  out  1              decoder accepts a bit this cycle
//   out_data   out  QUANT signed   decoded value
//   out_valid  out  1              out_data is valid
//   out_ready  in   1              downstream consumes out_data
//   busy       out  1              frame in progress or result held
// -----------------------------------------------------------------------------
module sc_bitstream_decoder #(
    parameter int BITSTREAM = 64,
    parameter int QUANT     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    bit_ready,
    output logic signed [QUANT-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int CNT_W = $clog2(BITSTREAM);
    localparam int SHIFT = QUANT - CNT_W;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(BITSTREAM - 1);
    localparam logic [CNT_W:0]   FULL_CNT  = (CNT_W + 1)'(BITSTREAM);
    localparam logic [QUANT-1:0] POS_MAX   = {1'b0, {(QUANT-1){1'b1}}};
    localparam logic [QUANT+1:0] MID_POINT = (QUANT + 2)'(2 ** (QUANT - 1));

    // Parameter legality checks at elaboration time.
    if ((BITSTREAM < 2) || ((BITSTREAM & (BITSTREAM - 1)) != 0)) begin : g_bad_bitstream
        $error("sc_bitstream_decoder: BITSTREAM must be a power of two");
    end
    if (QUANT < CNT_W) begin : g_bad_quant
        $error("sc_bitstream_decoder: QUANT must be >= $clog2(BITSTREAM)");
    end

    // Map a ones count onto the signed output range. The count is scaled up to
    // QUANT bits and offset by half scale, so a half-full frame reads as zero.
    // Only a completely full frame exceeds the positive limit.
    function automatic logic [QUANT-1:0] conv(input logic [CNT_W:0] n);
        logic [QUANT+1:0] ext_v;
        logic [QUANT+1:0] diff_v;
        ext_v  = (QUANT + 2)'(n) << SHIFT;
        diff_v = ext_v - MID_POINT;
        if (n == FULL_CNT) begin
            conv = POS_MAX;
        end else begin
            conv = diff_v[QUANT-1:0];
        end
    endfunction

    logic [0:0]       state_r,     state_s;
    logic [CNT_W-1:0] bit_cnt_r,   bit_cnt_s;
    logic [CNT_W:0]   ones_cnt_r,  ones_cnt_s;
    logic [CNT_W:0]   ones_f_s;
    logic [QUANT-1:0] out_data_r,  out_data_s;
    logic             out_valid_r, out_valid_s;

    // Next-state logic for the accumulate/hold controller and its counters.
    always_comb begin
        state_s     = state_r;
        bit_cnt_s   = bit_cnt_r;
        ones_cnt_s  = ones_cnt_r;
        out_data_s  = out_data_r;
        out_valid_s = out_valid_r;
        ones_f_s    = ones_cnt_r + (CNT_W + 1)'(bit_in);
        if (clear) begin
            // Flush wins over both bit acceptance and the output handshake.
            state_s     = ST_ACCUM;
            bit_cnt_s   = {CNT_W{1'b0}};
            ones_cnt_s  = {(CNT_W + 1){1'b0}};
            out_valid_s = 1'b0;
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (bit_valid) begin
                        if (bit_cnt_r == LAST_BIT) begin
                            // Last bit of the frame: include it in the result directly.
                            out_data_s  = conv(ones_f_s);
                            bit_cnt_s   = {CNT_W{1'b0}};
                            ones_cnt_s  = {(CNT_W + 1){1'b0}};
                            out_valid_s = 1'b1;
                            state_s     = ST_HOLD;
                        end else begin
                            bit_cnt_s  = bit_cnt_r + CNT_W'(1);
                            ones_cnt_s = ones_f_s;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_s = 1'b0;
                        state_s     = ST_ACCUM;
                    end else begin
                        out_valid_s = 1'b1;
                    end
                end
                default: begin
                    state_s     = ST_ACCUM;
                    bit_cnt_s   = {CNT_W{1'b0}};
                    ones_cnt_s  = {(CNT_W + 1){1'b0}};
                    out_valid_s = 1'b0;
                end
            endcase
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_ACCUM;
            bit_cnt_r   <= {CNT_W{1'b0}};
            ones_cnt_r  <= {(CNT_W + 1){1'b0}};
            out_data_r  <= {QUANT{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            bit_cnt_r   <= bit_cnt_s;
            ones_cnt_r  <= ones_cnt_s;
            out_data_r  <= out_data_s;
            out_valid_r <= out_valid_s;
        end
    end

    // Ready and busy are decoded straight from registered state.
    assign bit_ready = (state_r == ST_ACCUM);
    assign busy      = (bit_cnt_r != {CNT_W{1'b0}}) || (state_r == ST_HOLD);
    assign out_data  = $signed(out_data_r);
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// -----------------------------------------------------------------------------
// tb_sc_bitstream_decoder
//   Self-checking bench for sc_bitstream_decoder (BITSTREAM=64, QUANT=8).
//   A table of frames with hand-computed decoded values is applied in a loop,
//   followed by directed sequences for backpressure, clear and async reset.
// -----------------------------------------------------------------------------
module tb_sc_bitstream_decoder;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              bit_in;
    logic              bit_valid;
    logic              bit_ready;
    logic signed [7:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    int checks;
    int errors;

    typedef struct {
        string name;
        int    ones;
        bit    alt;
        bit    gaps;
        int    exp;
    } vec_t;

    vec_t vecs[8];

    sc_bitstream_decoder #(.BITSTREAM(64), .QUANT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // Send n bits; pattern: first 'ones' bits high, or alternating 1,0 with
    // 'ones' high bits. Optional idle gaps carry bit_in=1 to expose miscounting.
    task automatic send_bits(input int n, input int ones, input bit alt, input bit gaps);
        for (int i = 0; i < n; i++) begin
            logic b;
            if (gaps) begin
                int g;
                g = $urandom_range(0, 1);
                for (int k = 0; k < g; k++) begin
                    bit_valid = 1'b0;
                    bit_in    = 1'b1;
                    tick();
                end
                if ((g > 0) && (i > 0)) check("gap_busy", int'(busy), 1);
            end
            if (i == 63) check("pre_last_valid", int'(out_valid), 0);
            if (alt) b = ((i % 2) == 0) && ((i / 2) < ones);
            else     b = (i < ones);
            send_bit(b);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("consume_valid", int'(out_valid), 0);
        check("consume_ready", int'(bit_ready), 1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{"all_ones",   64, 1'b0, 1'b0,  127};
        vecs[1] = '{"all_zeros",   0, 1'b0, 1'b0, -128};
        vecs[2] = '{"alternate",  32, 1'b1, 1'b0,    0};
        vecs[3] = '{"ones_33",    33, 1'b0, 1'b0,    4};
        vecs[4] = '{"round_trip", 23, 1'b1, 1'b0,  -36};
        vecs[5] = '{"gaps_40",    40, 1'b0, 1'b1,   32};
        vecs[6] = '{"ones_1",      1, 1'b0, 1'b0, -124};
        vecs[7] = '{"ones_63",    63, 1'b0, 1'b0,  124};

        // Reset values.
        #12;
        check("rst_valid", int'(out_valid), 0);
        check("rst_data",  int'(out_data),  0);
        check("rst_ready", int'(bit_ready), 1);
        check("rst_busy",  int'(busy),      0);
        #1 rst_n = 1'b1;
        tick();

        // Table-driven frames.
        foreach (vecs[v]) begin
            send_bits(64, vecs[v].ones, vecs[v].alt, vecs[v].gaps);
            check({vecs[v].name, "_valid"}, int'(out_valid), 1);
            check({vecs[v].name, "_data"},  int'(out_data),  vecs[v].exp);
            check({vecs[v].name, "_busy"},  int'(busy),      1);
            consume();
        end

        // Backpressure: result held for 5 clocks while bits are offered.
        send_bits(64, 40, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            tick();
            check("bp_valid", int'(out_valid), 1);
            check("bp_data",  int'(out_data),  32);
            check("bp_ready", int'(bit_ready), 0);
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        consume();
        check("bp_busy_after", int'(busy), 0);

        // Clear after 20 bits (with a bit offered that cycle), then a clean frame.
        send_bits(20, 20, 1'b0, 1'b0);
        check("pre_clear_busy", int'(busy), 1);
        clear     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        clear     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        check("clear_busy", int'(busy), 0);
        send_bits(64, 64, 1'b0, 1'b0);
        check("clear_frame_valid", int'(out_valid), 1);
        check("clear_frame_data",  int'(out_data),  127);

        // Clear during HOLD beats a simultaneous handshake.
        clear     = 1'b1;
        out_ready = 1'b1;
        tick();
        clear     = 1'b0;
        out_ready = 1'b0;
        check("clear_hold_valid", int'(out_valid), 0);
        check("clear_hold_ready", int'(bit_ready), 1);
        check("clear_hold_busy",  int'(busy),      0);

        // Asynchronous reset mid-frame, after 30 bits.
        send_bits(30, 30, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_frame_busy",  int'(busy),      0);
        check("arst_frame_ready", int'(bit_ready), 1);
        #2 rst_n = 1'b1;
        tick();
        send_bits(64, 33, 1'b0, 1'b0);
        check("post_arst_valid", int'(out_valid), 1);
        check("post_arst_data",  int'(out_data),  4);

        // Asynchronous reset during HOLD.
        #2 rst_n = 1'b0;
        #1;
        check("arst_hold_valid", int'(out_valid), 0);
        check("arst_hold_data",  int'(out_data),  0);
        check("arst_hold_ready", int'(bit_ready), 1);
        check("arst_hold_busy",  int'(busy),      0);
        #2 rst_n = 1'b1;
        tick();
        send_bits(64, 0, 1'b0, 1'b0);
        check("post_arst2_data", int'(out_data), -128);
        consume();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
